seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side counterpart of the stopwatch's multiplexed seven-segment display driver. Samples the scanned segment/anode bus (4 digits, time-multiplexed), decodes each stable segment pattern back to a 4-bit digit value, and publishes a complete 4-digit frame once every digit position has been seen. Used for on-chip loopback checking of the display path and for reading external scanned displays.

## Interface

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured; legal range 2..255.
- SEG_ACTIVE_LOW, 1: 1 = segment lines active-low, 0 = active-high.
- AN_ACTIVE_LOW, 1: 1 = anode lines active-low, 0 = active-high.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- seg  input  7  segment lines, seg[0]=a … seg[6]=g.
- dp  input  1  decimal-point line, same polarity as seg.
- an  input  4  anode select; an[i] selects digit i.
- digits  output  16  last complete frame; digit i in digits[4i+3:4i].
- frame_valid  output  1  one-cycle pulse when digits updates.
- bad_seg  output  1  one-cycle pulse when an unrecognised pattern is captured.
- dp_out  output  4  decimal point per digit, updated with digits.

## Operation

- Input stage: seg, dp, an registered once; polarity normalised to active-high after the register.
- Anode qualification: exactly one bit active = valid; zero or multiple = blanking, stability counter cleared, no capture.
- Stability counter: increments while registered {an, seg, dp} equals the previous sample and anode valid; cleared on any change. Width $clog2(STABLE_CYCLES+1); saturates at STABLE_CYCLES.
- Capture: when counter reaches STABLE_CYCLES-1 and current sample still matches, capture exactly once per dwell (no recapture until the pattern or anode changes).
- Decode: standard hex patterns 0-9, A, b, C, d, E, F (a..g, active-high): 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71. Any other pattern, including all-off: bad_seg pulse, shadow and seen mask untouched.
- Frame assembly: valid capture writes shadow digit i and sets seen[i]. Re-capture of an already-seen position overwrites its shadow, no error. When seen becomes 4'hF: digits ← shadow (all four including the just-captured one), frame_valid pulses, seen cleared in the same edge.
- State: IDLE (counter 0 / blanking), SETTLE (counting), HELD (captured, waiting for change). HELD→SETTLE on pattern change with valid anode; any state→IDLE on invalid anode.

## Timing

- Reset: digits=0, dp_out=0, frame_valid=0, bad_seg=0; seen=0, shadow=0, counter=0, state IDLE, input register=inactive (anode invalid).
- Pattern present on inputs before edge E0 and held: capture occurs on edge E0+STABLE_CYCLES; frame_valid/bad_seg/digits visible after that edge.
- frame_valid and bad_seg are mutually exclusive per cycle (one capture per cycle max).
- Reset mid-frame: partial seen mask and shadow discarded; no frame_valid.
- Pattern change one cycle before capture edge: no capture, counter restarts.

## Configuration

- SEG_SCAN_DECODER_DP_EN defined: dp sampled and compared for stability; captured per digit into shadow; dp_out updated with digits.
- Not defined: dp input ignored (excluded from stability compare), dp_out tied to 4'b0000.

## Structure

- Package seg_decode_pkg: 7-bit pattern constants for 0-F, SEG_W=7, DIGITS=4, state enum type.
- Sub-module seg7_pattern_decode: combinational pattern→{valid, value[3:0]} lookup; everything else in seg_scan_decoder.

## Test plan

- Reset: assert rst_n=0 mid-activity -> all outputs 0 immediately; after release, first frame requires all four digits again.
- Clean scan: digits 1,2,3,4 on an[0..3] (active-low, seg 0x06,0x5B,0x4F,0x66 inverted), 8 cycles each -> one frame_valid, digits=16'h4321, bad_seg never.
- Short dwell: digit held 3 cycles with STABLE_CYCLES=4 -> no capture, seen unchanged, no frame_valid.
- Invalid pattern: seg=0x00 on an[2] for 8 cycles -> one bad_seg pulse, no frame_valid until a valid an[2] capture.
- Overwrite/blanking: an[0] shows 5 then 7, an=4'b1111 blanking between, then an[1..3] valid -> frame digits[3:0]=7; multiple-hot an=4'b0011 produces no capture.
- DP (SEG_SCAN_DECODER_DP_EN defined): dp active on digit 2 only -> dp_out=4'b0100 with frame_valid; macro undefined -> dp_out=0.

Source files
------------

// File: rtl/seg_decode_pkg.sv
// Shared constants and types for the scanned seven-segment receive path.
package seg_decode_pkg;

  localparam int SEG_W  = 7;
  localparam int DIGITS = 4;
  localparam int VAL_W  = 4;

  // a..g active-high, seg[0]=a
  localparam logic [SEG_W-1:0] PAT_0 = 7'h3F;
  localparam logic [SEG_W-1:0] PAT_1 = 7'h06;
  localparam logic [SEG_W-1:0] PAT_2 = 7'h5B;
  localparam logic [SEG_W-1:0] PAT_3 = 7'h4F;
  localparam logic [SEG_W-1:0] PAT_4 = 7'h66;
  localparam logic [SEG_W-1:0] PAT_5 = 7'h6D;
  localparam logic [SEG_W-1:0] PAT_6 = 7'h7D;
  localparam logic [SEG_W-1:0] PAT_7 = 7'h07;
  localparam logic [SEG_W-1:0] PAT_8 = 7'h7F;
  localparam logic [SEG_W-1:0] PAT_9 = 7'h6F;
  localparam logic [SEG_W-1:0] PAT_A = 7'h77;
  localparam logic [SEG_W-1:0] PAT_B = 7'h7C;
  localparam logic [SEG_W-1:0] PAT_C = 7'h39;
  localparam logic [SEG_W-1:0] PAT_D = 7'h5E;
  localparam logic [SEG_W-1:0] PAT_E = 7'h79;
  localparam logic [SEG_W-1:0] PAT_F = 7'h71;

  localparam logic [15:0][SEG_W-1:0] PAT_TABLE = {
    PAT_F, PAT_E, PAT_D, PAT_C, PAT_B, PAT_A, PAT_9, PAT_8,
    PAT_7, PAT_6, PAT_5, PAT_4, PAT_3, PAT_2, PAT_1, PAT_0
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [DIGITS-1:0] an;
    logic [SEG_W-1:0]  seg;
    logic              dp;
  } scan_smp_t;

  function automatic logic onehot_an(input logic [DIGITS-1:0] v);
    return (v != '0) && ((v & (v - DIGITS'(1))) == '0);
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern to hex value lookup (active-high a..g).
module seg7_pattern_decode
  import seg_decode_pkg::*;
(
  input  logic [SEG_W-1:0] pat,
  output logic             valid,
  output logic [VAL_W-1:0] value
);

  always_comb begin
    valid = 1'b0;
    value = '0;
    for (int i = 0; i < 16; i++) begin
      if (pat == PAT_TABLE[i]) begin
        valid = 1'b1;
        value = VAL_W'(i);
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed 4-digit seven-segment bus and rebuilds full digit frames.
// Optional decimal-point capture is enabled with SEG_SCAN_DECODER_DP_EN.
module seg_scan_decoder
  import seg_decode_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEG_W-1:0]        seg,
  input  logic                    dp,
  input  logic [DIGITS-1:0]       an,
  output logic [DIGITS*VAL_W-1:0] digits,
  output logic                    frame_valid,
  output logic                    bad_seg,
  output logic [DIGITS-1:0]       dp_out
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 1);
  // XOR mask turning raw lines into active-high; also the raw "all inactive" value.
  localparam scan_smp_t INV_MASK = '{an:  {DIGITS{AN_ACTIVE_LOW}},
                                     seg: {SEG_W{SEG_ACTIVE_LOW}},
                                     dp:  SEG_ACTIVE_LOW};

  scan_smp_t   smp_d, smp_q, norm_d, norm_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  scan_state_e state_d, state_q;
  logic        an_ok_d, an_ok_q, match, capture;
  logic        dec_valid;
  logic [VAL_W-1:0] dec_value;

  logic [DIGITS-1:0][VAL_W-1:0] shadow_d, shadow_q, digits_d, digits_q;
  logic [DIGITS-1:0] seen_d, seen_q;
  logic [DIGITS-1:0] dpsh_d, dpsh_q, dp_out_d, dp_out_q;
  logic        frame_valid_d, frame_valid_q, bad_seg_d, bad_seg_q;

  always_comb begin
    smp_d     = '0;
    smp_d.an  = an;
    smp_d.seg = seg;
`ifdef SEG_SCAN_DECODER_DP_EN
    smp_d.dp  = dp;
`else
    smp_d.dp  = INV_MASK.dp;
`endif
  end

`ifndef SEG_SCAN_DECODER_DP_EN
  logic unused_dp;
  assign unused_dp = dp;
`endif

  assign norm_d  = smp_d ^ INV_MASK;
  assign norm_q  = smp_q ^ INV_MASK;
  assign an_ok_d = onehot_an(norm_d.an);
  assign an_ok_q = onehot_an(norm_q.an);

  // The sample being registered is compared with the one already held, so a
  // pattern present before edge E0 is captured on edge E0+STABLE_CYCLES.
  assign match   = (smp_d == smp_q) && an_ok_q;
  assign capture = match && (cnt_q == CNT_CAP) && (state_q != ST_HELD);

  seg7_pattern_decode u_dec (
    .pat   (norm_q.seg),
    .valid (dec_valid),
    .value (dec_value)
  );

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (!match) begin
      cnt_d   = '0;
      state_d = an_ok_d ? ST_SETTLE : ST_IDLE;
    end else begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      if (capture)                 state_d = ST_HELD;
      else if (state_q == ST_IDLE) state_d = ST_SETTLE;
    end
  end

  always_comb begin
    shadow_d      = shadow_q;
    dpsh_d        = dpsh_q;
    seen_d        = seen_q;
    digits_d      = digits_q;
    dp_out_d      = dp_out_q;
    frame_valid_d = 1'b0;
    bad_seg_d     = 1'b0;
    if (capture) begin
      if (dec_valid) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (norm_q.an[i]) begin
            shadow_d[i] = dec_value;
            dpsh_d[i]   = norm_q.dp;
          end
        end
        seen_d = seen_q | norm_q.an;
        if (seen_d == '1) begin
          digits_d      = shadow_d;
          dp_out_d      = dpsh_d;
          frame_valid_d = 1'b1;
          seen_d        = '0;
        end
      end else begin
        bad_seg_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q         <= INV_MASK;
      cnt_q         <= '0;
      state_q       <= ST_IDLE;
      shadow_q      <= '0;
      dpsh_q        <= '0;
      seen_q        <= '0;
      digits_q      <= '0;
      dp_out_q      <= '0;
      frame_valid_q <= 1'b0;
      bad_seg_q     <= 1'b0;
    end else begin
      smp_q         <= smp_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      dpsh_q        <= dpsh_d;
      seen_q        <= seen_d;
      digits_q      <= digits_d;
      dp_out_q      <= dp_out_d;
      frame_valid_q <= frame_valid_d;
      bad_seg_q     <= bad_seg_d;
    end
  end

  assign digits      = digits_q;
  assign frame_valid = frame_valid_q;
  assign bad_seg     = bad_seg_q;
`ifdef SEG_SCAN_DECODER_DP_EN
  assign dp_out      = dp_out_q;
`else
  assign dp_out      = '0;
  logic unused_dp_out;
  assign unused_dp_out = ^dp_out_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: stimulus pushes expected events, monitor pops them.
module tb_seg_scan_decoder;

  localparam int ST = 4;
`ifdef SEG_SCAN_DECODER_DP_EN
  localparam bit DPE = 1'b1;
`else
  localparam bit DPE = 1'b0;
`endif
  localparam logic [6:0] P [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] seg;
  logic dp;
  logic [3:0] an;
  logic [15:0] digits;
  logic frame_valid, bad_seg;
  logic [3:0] dp_out;

  seg_scan_decoder #(.STABLE_CYCLES(ST), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .dp(dp), .an(an),
    .digits(digits), .frame_valid(frame_valid), .bad_seg(bad_seg), .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 1 frame, 2 bad_seg
    logic [15:0] dig;
    logic [3:0]  dpo;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // an_ah/seg_ah/dp_ah are active-high views; the bus itself is active-low.
  task automatic drive(input logic [3:0] an_ah, input logic [6:0] seg_ah, input logic dp_ah,
                       input int n, input int kind, input logic [15:0] dg, input logic [3:0] dpo);
    exp_t e;
    #1;
    an  = ~an_ah;
    seg = ~seg_ah;
    dp  = ~dp_ah;
    if (kind != 0) begin
      e.kind = kind;
      e.dig  = dg;
      e.dpo  = DPE ? dpo : 4'h0;
      e.cyc  = cyc + 1 + ST;
      q.push_back(e);
    end
    repeat (n) @(posedge clk);
  endtask

  task automatic show(input int pos, input int val, input int n);
    drive(4'b0001 << pos, P[val], 1'b0, n, 0, 16'h0, 4'h0);
  endtask

  always @(negedge clk) begin
    if (rst_n && (frame_valid || bad_seg)) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: frame_valid=%0b bad_seg=%0b digits=%h, none expected (cycle %0d)",
                 frame_valid, bad_seg, digits, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("event_kind", bad_seg ? 2 : 1, e.kind);
        chk("exclusive", {31'd0, frame_valid & bad_seg}, 0);
        if (e.kind == 1) begin
          chk("frame_digits", {16'd0, digits}, {16'd0, e.dig});
          chk("frame_dp_out", {28'd0, dp_out}, {28'd0, e.dpo});
        end
        chk("event_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  initial begin
    #100000;
    tests++;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    an    = 4'hF;
    seg   = 7'h7F;
    dp    = 1'b1;
    #12;
    chk("rst_digits", {16'd0, digits}, 0);
    chk("rst_frame_valid", {31'd0, frame_valid}, 0);
    chk("rst_bad_seg", {31'd0, bad_seg}, 0);
    chk("rst_dp_out", {28'd0, dp_out}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);

    // clean scan 1,2,3,4
    show(0, 1, 8);
    show(1, 2, 8);
    show(2, 3, 8);
    drive(4'b1000, P[4], 1'b0, 8, 1, 16'h4321, 4'h0);

    // short dwell on position 0 must not count
    show(0, 9, 3);
    show(1, 5, 8);
    show(2, 6, 8);
    show(3, 7, 8);
    drive(4'b0001, P[8], 1'b0, 8, 1, 16'h7658, 4'h0);

    // unrecognised pattern (all off) on position 2
    drive(4'b0100, 7'h00, 1'b0, 8, 2, 16'h0, 4'h0);
    show(0, 1, 8);
    show(1, 2, 8);
    show(3, 3, 8);
    drive(4'b0100, P[10], 1'b0, 8, 1, 16'h3A21, 4'h0);

    // overwrite with blanking between, then a multi-hot anode
    show(0, 5, 8);
    drive(4'b0000, P[8], 1'b0, 4, 0, 16'h0, 4'h0);
    show(0, 7, 8);
    drive(4'b0011, P[8], 1'b0, 8, 0, 16'h0, 4'h0);
    show(1, 11, 8);
    show(2, 12, 8);
    drive(4'b1000, P[13], 1'b0, 8, 1, 16'hDCB7, 4'h0);

    // decimal point on digit 2 only
    show(0, 0, 8);
    show(1, 15, 8);
    drive(4'b0100, P[14], 1'b1, 8, 0, 16'h0, 4'h0);
    drive(4'b1000, P[8], 1'b0, 8, 1, 16'h8EF0, 4'b0100);

    // reset mid-frame discards the partial frame
    show(0, 1, 8);
    show(1, 2, 8);
    drive(4'b0000, 7'h00, 1'b0, 2, 0, 16'h0, 4'h0);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_digits", {16'd0, digits}, 0);
    chk("midrst_frame_valid", {31'd0, frame_valid}, 0);
    chk("midrst_bad_seg", {31'd0, bad_seg}, 0);
    chk("midrst_dp_out", {28'd0, dp_out}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    show(2, 3, 8);
    show(3, 4, 8);
    show(0, 5, 8);
    drive(4'b0010, P[6], 1'b0, 8, 1, 16'h4365, 4'h0);

    drive(4'b0000, 7'h00, 1'b0, 10, 0, 16'h0, 4'h0);
    chk("queue_empty", q.size(), 0);
    summary();
    $finish;
  end

endmodule
